sdram_bridge: RTL
=================

SDRAM_BRIDGE -- requirements
Module: sdram_bridge

Interface
REQ-001 SHALL have parameter AW, default 21, CPU word-address width.
REQ-002 SHALL have parameter DW, default 16, data width; legal values 16 or 32; SW = DW/8 byte lanes.
REQ-003 SHALL have parameter RST_DLY, default 4, clk_p cycles from reset release to ctl_rst_n high (range 1..255).
REQ-004 SHALL have parameter TMO_CYC, default 255, maximum cycles to wait for a controller acknowledge (range 1..65535).
REQ-005 SHALL have the following ports, in this order:
- clk_p  in  1  single clock; all logic on rising edge.
- sdram_reset  in  1  synchronous active-high reset.
- sdram_stb  in  1  CPU transaction strobe.
- sdram_we  in  1  1 = write, 0 = read.
- sdram_sel  in  SW  byte selects, active high.
- sdram_adr  in  AW  word address.
- sdram_out  in  DW  write data from CPU.
- sdram_dat  out  DW  read data to CPU.
- sdram_ack  out  1  transaction acknowledge.
- sdram_ready  out  1  SDRAM initialised.
- ctl_rst_n  out  1  controller reset, active low.
- ctl_wr_req  out  1  write request.
- ctl_rd_req  out  1  read request.
- ctl_wr_ack  in  1  write accepted.
- ctl_rd_ack  in  1  read data valid.
- ctl_adr  out  AW  latched address.
- ctl_wdata  out  DW  latched write data.
- ctl_rdata  in  DW  read data.
- ctl_dm  out  SW  data mask, 1 = lane masked.
- ctl_init_done  in  1  controller initialisation complete.
- tmo_err  out  1  sticky timeout flag.

Function
REQ-006 SHALL implement FSM states RST_WAIT, IDLE, WREQ, RREQ, DONE.
REQ-007 RST_WAIT: ctl_rst_n = 0; counter increments from 0; at count RST_DLY-1, ctl_rst_n <= 1 and state <= IDLE.
REQ-008 sdram_ready SHALL equal the registered ctl_init_done AND ctl_rst_n.
REQ-009 IDLE with sdram_stb=1 and sdram_ready=1: latch adr, out and sel; ctl_dm <= ~sel on write, all zeros on read; go to WREQ if we=1, else RREQ.
REQ-010 ctl_wr_req=1 only in WREQ; ctl_rd_req=1 only in RREQ; both are registered and never high together.
REQ-011 WREQ/RREQ: on the matching ctl_*_ack, go to DONE; on RREQ, ctl_rdata is captured into sdram_dat in the same cycle.
REQ-012 sdram_ack SHALL equal sdram_stb AND (state==DONE); first high one cycle after the controller ack is sampled.
REQ-013 DONE: return to IDLE in the first cycle sdram_stb=0; sdram_ack then drops combinationally.
REQ-014 Timeout: a cycle counter runs in WREQ/RREQ; on reaching TMO_CYC without ack, go to DONE, set tmo_err=1 (sticky until reset), and leave sdram_dat unchanged.
REQ-015 sdram_stb dropped while in WREQ/RREQ: the request SHALL complete; no ack is produced and the FSM then returns to IDLE.
REQ-016 sdram_stb high while sdram_ready=0: the bridge SHALL stay in IDLE and issue no request.
REQ-017 A write ack arriving during RREQ, or a read ack during WREQ, SHALL be ignored.

Reset
REQ-018 sdram_reset=1 SHALL force, at the next edge: state RST_WAIT, counters 0, ctl_rst_n=0, both requests 0, sdram_dat=0, ctl_adr=0, ctl_wdata=0, ctl_dm=0, tmo_err=0.
REQ-019 A reset asserted mid-transaction SHALL abort it and drop the request in the same cycle; no ack is issued.

Configuration
REQ-020 Macro SDRAM_WPOST_EN enables write posting.
- Defined: an IDLE write latches into a one-entry buffer and enters WREQ; sdram_ack is high the cycle after latch, while stb=1. A new request arriving while the buffer is not drained stalls in IDLE until the write ack.
- Undefined: write acknowledge follows REQ-012. Read behaviour is identical in both builds.

Verification
REQ-021 Release reset with RST_DLY=4 -> ctl_rst_n rises exactly 4 cycles after reset deasserts; sdram_ready stays 0 until ctl_init_done=1.
REQ-022 Write adr=0x1234, out=0xBEEF, sel=2'b10 -> ctl_dm=2'b01 and ctl_wr_req=1; ack 3 cycles later -> sdram_ack high the next cycle, low the cycle stb drops.
REQ-023 Read adr=0x0010 with ctl_rdata=0x5A5A on rd_ack -> sdram_dat=0x5A5A with sdram_ack; ctl_dm=0.
REQ-024 Read with no controller ack, TMO_CYC=8 -> DONE after 8 cycles, tmo_err=1, sdram_dat unchanged.
REQ-025 sdram_reset pulsed during WREQ -> ctl_wr_req=0 next cycle, no sdram_ack, FSM in RST_WAIT.
REQ-026 With SDRAM_WPOST_EN defined: write then immediate read -> write acked in 1 cycle; read request waits until ctl_wr_ack, then proceeds.

Source files
------------

// File: rtl/sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bridge
// Purpose  : Bridges a simple CPU strobe/acknowledge bus to an SDRAM
//            controller request/acknowledge interface. Holds the controller
//            in reset for RST_DLY cycles, latches one CPU transaction at a
//            time, forwards it as a write or read request, and guards every
//            request with a TMO_CYC cycle timeout (sticky tmo_err).
// Revision : 1.0 - initial release
//
// Parameters
//   AW      CPU word-address width
//   DW      data width (16 or 32), DW/8 byte lanes
//   RST_DLY cycles from reset release to ctl_rst_n high (1..255)
//   TMO_CYC cycles to wait for a controller acknowledge (1..65535)
//
// Ports
//   clk_p, sdram_reset                  clock, synchronous active-high reset
//   sdram_stb/we/sel/adr/out            CPU request side
//   sdram_dat/ack/ready                 CPU response side
//   ctl_rst_n, ctl_wr_req, ctl_rd_req   controller control outputs
//   ctl_wr_ack, ctl_rd_ack, ctl_rdata   controller responses
//   ctl_adr, ctl_wdata, ctl_dm          latched request payload
//   ctl_init_done                       controller initialisation complete
//   tmo_err                             sticky timeout flag
//
// Build option
//   SDRAM_WPOST_EN  write posting: an IDLE write is acknowledged to the CPU
//                   the cycle after it is latched; later requests wait in
//                   IDLE until the controller accepts the posted write.
// ============================================================================
module sdram_bridge #(
  parameter int AW      = 21,
  parameter int DW      = 16,
  parameter int RST_DLY = 4,
  parameter int TMO_CYC = 255
) (
  input  logic              clk_p,
  input  logic              sdram_reset,
  input  logic              sdram_stb,
  input  logic              sdram_we,
  input  logic [DW/8-1:0]   sdram_sel,
  input  logic [AW-1:0]     sdram_adr,
  input  logic [DW-1:0]     sdram_out,
  output logic [DW-1:0]     sdram_dat,
  output logic              sdram_ack,
  output logic              sdram_ready,
  output logic              ctl_rst_n,
  output logic              ctl_wr_req,
  output logic              ctl_rd_req,
  input  logic              ctl_wr_ack,
  input  logic              ctl_rd_ack,
  output logic [AW-1:0]     ctl_adr,
  output logic [DW-1:0]     ctl_wdata,
  input  logic [DW-1:0]     ctl_rdata,
  output logic [DW/8-1:0]   ctl_dm,
  input  logic              ctl_init_done,
  output logic              tmo_err
);

  localparam int         SW       = DW / 8;
  localparam logic [7:0]  RST_LAST = 8'(RST_DLY - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    IDLE     = 3'd1,
    WREQ     = 3'd2,
    RREQ     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          state_q,     state_d;
  logic [7:0]      rst_cnt_q,   rst_cnt_d;
  logic [15:0]     tmo_cnt_q,   tmo_cnt_d;
  logic            ctl_rst_n_q, ctl_rst_n_d;
  logic            wr_req_q,    wr_req_d;
  logic            rd_req_q,    rd_req_d;
  logic [DW-1:0]   dat_q,       dat_d;
  logic [AW-1:0]   adr_q,       adr_d;
  logic [DW-1:0]   wdata_q,     wdata_d;
  logic [SW-1:0]   dm_q,        dm_d;
  logic            tmo_err_q,   tmo_err_d;
  logic            init_done_q;
  logic            post_ack_q,  post_ack_d;
  logic            ready;

  assign ready = init_done_q & ctl_rst_n_q;

`ifdef SDRAM_WPOST_EN
  // A posted write has already been acknowledged to the CPU, so a finished
  // write request goes straight back to IDLE instead of waiting in DONE.
  localparam state_t WR_END = IDLE;
  localparam logic   POSTED = 1'b1;
`else
  localparam state_t WR_END = DONE;
  localparam logic   POSTED = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    ctl_rst_n_d = ctl_rst_n_q;
    wr_req_d    = wr_req_q;
    rd_req_d    = rd_req_q;
    dat_d       = dat_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    dm_d        = dm_q;
    tmo_err_d   = tmo_err_q;
    post_ack_d  = 1'b0;   // single-cycle pulse

    case (state_q)
      RST_WAIT: begin
        ctl_rst_n_d = 1'b0;
        if (rst_cnt_q == RST_LAST) begin
          ctl_rst_n_d = 1'b1;
          rst_cnt_d   = '0;
          state_d     = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end

      IDLE: begin
        tmo_cnt_d = '0;
        if (sdram_stb && ready) begin
          adr_d   = sdram_adr;
          wdata_d = sdram_out;
          if (sdram_we) begin
            dm_d       = ~sdram_sel;
            wr_req_d   = 1'b1;
            post_ack_d = POSTED;
            state_d    = WREQ;
          end else begin
            dm_d     = '0;
            rd_req_d = 1'b1;
            state_d  = RREQ;
          end
        end
      end

      // A read ack seen here is deliberately ignored.
      WREQ: begin
        if (ctl_wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = WR_END;
        end else if (tmo_cnt_q == TMO_LAST) begin
          wr_req_d  = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = WR_END;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      // A write ack seen here is deliberately ignored; on timeout the
      // previous read data is kept.
      RREQ: begin
        if (ctl_rd_ack) begin
          rd_req_d = 1'b0;
          dat_d    = ctl_rdata;
          state_d  = DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rd_req_d  = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      DONE: begin
        if (!sdram_stb) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = RST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      state_q     <= RST_WAIT;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      ctl_rst_n_q <= 1'b0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      dat_q       <= '0;
      adr_q       <= '0;
      wdata_q     <= '0;
      dm_q        <= '0;
      tmo_err_q   <= 1'b0;
      init_done_q <= 1'b0;
      post_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ctl_rst_n_q <= ctl_rst_n_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      dat_q       <= dat_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      dm_q        <= dm_d;
      tmo_err_q   <= tmo_err_d;
      init_done_q <= ctl_init_done;
      post_ack_q  <= post_ack_d;
    end
  end

  // The acknowledge follows the strobe combinationally so it falls in the
  // same cycle the CPU withdraws its request.
  assign sdram_ack   = sdram_stb & ((state_q == DONE) | post_ack_q);
  assign sdram_dat   = dat_q;
  assign sdram_ready = ready;
  assign ctl_rst_n   = ctl_rst_n_q;
  assign ctl_wr_req  = wr_req_q;
  assign ctl_rd_req  = rd_req_q;
  assign ctl_adr     = adr_q;
  assign ctl_wdata   = wdata_q;
  assign ctl_dm      = dm_q;
  assign tmo_err     = tmo_err_q;

endmodule
`default_nettype wire
